// File: rtl/io_bridge_pkg.sv
// rtl/io_bridge_pkg.sv - shared types and constants for the PS/2 / LCD I/O bridge
package io_bridge_pkg;

    // LCD drain FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } drain_state_e;

    localparam int PS2_W         = 8;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_KEY_DEPTH = 8;
    localparam int DEF_LCD_DEPTH = 4;
    localparam int DEF_LCD_GAP   = 2;

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - show-ahead synchronous FIFO allowing push and pop together when full
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push needs, so a full FIFO still accepts it
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage, pointers and occupancy registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ps2_lcd_io_bridge.sv
// rtl/ps2_lcd_io_bridge.sv - PS/2 key capture FIFO and paced LCD write FIFO for the processor
module ps2_lcd_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int KEY_DEPTH = DEF_KEY_DEPTH,
    parameter int LCD_DEPTH = DEF_LCD_DEPTH,
    parameter int LCD_GAP   = DEF_LCD_GAP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ps2_key_pressed,
    input  logic [PS2_W-1:0]  ps2_out,
    input  logic              proc_key_rd,
    output logic              proc_key_valid,
    output logic [PS2_W-1:0]  proc_key_data,
    input  logic              proc_lcd_write,
    input  logic [DATA_W-1:0] proc_lcd_data,
    output logic              proc_lcd_full,
    input  logic              lcd_busy,
    output logic              lcd_write,
    output logic [DATA_W-1:0] lcd_data,
    input  logic              status_clr,
    output logic              key_ovf,
    output logic              lcd_ovf
);

    localparam int GW = $clog2(LCD_GAP) + 1;

    logic                     key_prev_q, key_prev_d;
    logic                     key_push, key_pop;
    logic [PS2_W-1:0]         key_head;
    logic                     key_full, key_empty;
    logic [$clog2(KEY_DEPTH):0] key_count;

    logic                     lcd_pop;
    logic [DATA_W-1:0]        lcd_head;
    logic                     lcd_full_w, lcd_empty;
    logic [$clog2(LCD_DEPTH):0] lcd_count;

    drain_state_e             state_q, state_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic                     lcd_write_q, lcd_write_d;
    logic [DATA_W-1:0]        lcd_data_q, lcd_data_d;
    logic                     key_ovf_q, key_ovf_d;
    logic                     lcd_ovf_q, lcd_ovf_d;

    io_sync_fifo #(.WIDTH(PS2_W), .DEPTH(KEY_DEPTH)) u_key_fifo (
        .clock (clock),
        .reset (reset),
        .push  (key_push),
        .pop   (key_pop),
        .wdata (ps2_out),
        .rdata (key_head),
        .full  (key_full),
        .empty (key_empty),
        .count (key_count)
    );

    io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(LCD_DEPTH)) u_lcd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (proc_lcd_write),
        .pop   (lcd_pop),
        .wdata (proc_lcd_data),
        .rdata (lcd_head),
        .full  (lcd_full_w),
        .empty (lcd_empty),
        .count (lcd_count)
    );

    assign proc_key_valid = (key_count != '0);
    assign proc_key_data  = key_empty ? '0 : key_head;
    assign proc_lcd_full  = (lcd_count == ($clog2(LCD_DEPTH)+1)'(LCD_DEPTH));
    assign lcd_write      = lcd_write_q;
    assign lcd_data       = lcd_data_q;
    assign key_ovf        = key_ovf_q;
    assign lcd_ovf        = lcd_ovf_q;

    // Key side: one push per strobe rising edge, pop only when something is there
    always_comb begin
        key_prev_d = ps2_key_pressed;
        key_push   = ps2_key_pressed & ~key_prev_q;
        key_pop    = proc_key_rd & ~key_empty;
    end

    // Drain FSM: pop into the output register, then hold off for the gap
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        lcd_pop     = 1'b0;
        lcd_write_d = 1'b0;
        lcd_data_d  = lcd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (!lcd_empty && !lcd_busy) begin
                    lcd_pop     = 1'b1;
                    lcd_write_d = 1'b1;
                    lcd_data_d  = lcd_head;
                    gap_d       = GW'(LCD_GAP - 1);
                    state_d     = (LCD_GAP == 1) ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky drop flags; a clear wins over a same-cycle drop
    always_comb begin
        key_ovf_d = key_ovf_q | (key_push & key_full & ~key_pop);
        lcd_ovf_d = lcd_ovf_q | (proc_lcd_write & lcd_full_w & ~lcd_pop);
        if (status_clr) begin
            key_ovf_d = 1'b0;
            lcd_ovf_d = 1'b0;
        end
    end

    // State, output and flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            lcd_write_q <= 1'b0;
            lcd_data_q  <= '0;
            key_ovf_q   <= 1'b0;
            lcd_ovf_q   <= 1'b0;
        end else begin
            key_prev_q  <= key_prev_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            lcd_write_q <= lcd_write_d;
            lcd_data_q  <= lcd_data_d;
            key_ovf_q   <= key_ovf_d;
            lcd_ovf_q   <= lcd_ovf_d;
        end
    end

endmodule

// File: tb/tb_ps2_lcd_io_bridge.sv
// tb/tb_ps2_lcd_io_bridge.sv - scoreboard bench for the PS/2 / LCD I/O bridge
module tb_ps2_lcd_io_bridge;

    localparam int DATA_W    = 32;
    localparam int KEY_DEPTH = 8;
    localparam int LCD_DEPTH = 4;
    localparam int LCD_GAP   = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ps2_key_pressed = 1'b0;
    logic [7:0]        ps2_out = '0;
    logic              proc_key_rd = 1'b0;
    logic              proc_key_valid;
    logic [7:0]        proc_key_data;
    logic              proc_lcd_write = 1'b0;
    logic [DATA_W-1:0] proc_lcd_data = '0;
    logic              proc_lcd_full;
    logic              lcd_busy = 1'b0;
    logic              lcd_write;
    logic [DATA_W-1:0] lcd_data;
    logic              status_clr = 1'b0;
    logic              key_ovf;
    logic              lcd_ovf;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } lcd_exp_t;

    lcd_exp_t   lcd_q[$];
    logic [7:0] key_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         lcd_seen = 0;
    int         p, r, s0;

    ps2_lcd_io_bridge #(
        .DATA_W(DATA_W), .KEY_DEPTH(KEY_DEPTH), .LCD_DEPTH(LCD_DEPTH), .LCD_GAP(LCD_GAP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .proc_key_rd     (proc_key_rd),
        .proc_key_valid  (proc_key_valid),
        .proc_key_data   (proc_key_data),
        .proc_lcd_write  (proc_lcd_write),
        .proc_lcd_data   (proc_lcd_data),
        .proc_lcd_full   (proc_lcd_full),
        .lcd_busy        (lcd_busy),
        .lcd_write       (lcd_write),
        .lcd_data        (lcd_data),
        .status_clr      (status_clr),
        .key_ovf         (key_ovf),
        .lcd_ovf         (lcd_ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [7:0] code, input int len);
        ps2_out = code;
        ps2_key_pressed = 1'b1;
        step(len);
        ps2_key_pressed = 1'b0;
        step(1);
    endtask

    // LCD monitor: every write pulse must match the next expected word and cycle
    always @(negedge clock) begin
        lcd_exp_t e;
        if (!reset && lcd_write) begin
            lcd_seen++;
            if (lcd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lcd_unexpected actual=%0h expected=none (cycle %0d)", lcd_data, cyc);
            end else begin
                e = lcd_q.pop_front();
                check("lcd_data", lcd_data, e.data);
                if (e.cyc >= 0) check("lcd_cycle", cyc, e.cyc);
            end
        end
    end

    // Key monitor: every accepted pop must show the next expected scan code
    always @(negedge clock) begin
        logic [7:0] k;
        if (!reset && proc_key_rd && proc_key_valid) begin
            if (key_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL key_unexpected actual=%0h expected=none (cycle %0d)", proc_key_data, cyc);
            end else begin
                k = key_q.pop_front();
                check("key_data", proc_key_data, k);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        check("rst_key_valid", proc_key_valid, 0);
        check("rst_key_data", proc_key_data, 0);
        check("rst_lcd_full", proc_lcd_full, 0);
        check("rst_lcd_write", lcd_write, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_key_ovf", key_ovf, 0);
        check("rst_lcd_ovf", lcd_ovf, 0);
        reset = 1'b0;
        step(1);

        // 1: long strobe gives exactly one entry
        key_q.push_back(8'h1C);
        strobe(8'h1C, 5);
        check("t1_valid", proc_key_valid, 1);
        check("t1_data", proc_key_data, 8'h1C);
        proc_key_rd = 1'b1;
        step(1);
        proc_key_rd = 1'b0;
        check("t1_valid_after", proc_key_valid, 0);
        check("t1_data_after", proc_key_data, 0);

        // 2: nine strobes into eight entries
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) key_q.push_back(8'(i));
            strobe(8'(i), 1);
        end
        check("t2_key_ovf", key_ovf, 1);
        proc_key_rd = 1'b1;
        step(8);
        proc_key_rd = 1'b0;
        check("t2_empty", proc_key_valid, 0);
        check("t2_key_ovf_sticky", key_ovf, 1);
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        check("t2_key_ovf_clr", key_ovf, 0);

        // 3: push and pop in the same cycle while full
        for (int i = 0; i < 8; i++) begin
            key_q.push_back(8'h21 + 8'(i));
            strobe(8'h21 + 8'(i), 1);
        end
        key_q.push_back(8'h29);
        ps2_out = 8'h29;
        ps2_key_pressed = 1'b1;
        proc_key_rd = 1'b1;
        step(1);
        ps2_key_pressed = 1'b0;
        proc_key_rd = 1'b0;
        step(1);
        check("t3_no_ovf", key_ovf, 0);
        check("t3_valid", proc_key_valid, 1);
        proc_key_rd = 1'b1;
        step(8);
        proc_key_rd = 1'b0;
        check("t3_drained", proc_key_valid, 0);

        // 4: three consecutive LCD pushes paced three cycles apart
        proc_lcd_write = 1'b1;
        proc_lcd_data = 32'hA;
        step(1);
        p = cyc;
        lcd_q.push_back('{32'hA, p + 1});
        proc_lcd_data = 32'hB;
        step(1);
        lcd_q.push_back('{32'hB, p + 4});
        proc_lcd_data = 32'hC;
        step(1);
        lcd_q.push_back('{32'hC, p + 7});
        proc_lcd_write = 1'b0;
        step(10);
        check("t4_drained", lcd_q.size(), 0);
        check("t4_data_held", lcd_data, 32'hC);

        // 5: busy LCD, fill, overflow, then drain
        lcd_busy = 1'b1;
        s0 = lcd_seen;
        proc_lcd_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            proc_lcd_data = 32'hD0 + 32'(i);
            step(1);
        end
        proc_lcd_write = 1'b0;
        check("t5_full", proc_lcd_full, 1);
        check("t5_no_ovf", lcd_ovf, 0);
        proc_lcd_write = 1'b1;
        proc_lcd_data = 32'hEE;
        step(1);
        proc_lcd_write = 1'b0;
        check("t5_lcd_ovf", lcd_ovf, 1);
        step(3);
        check("t5_no_write_busy", lcd_seen, s0);
        lcd_busy = 1'b0;
        r = cyc;
        for (int i = 0; i < 4; i++) lcd_q.push_back('{32'hD0 + 32'(i), r + 1 + 3 * i});
        status_clr = 1'b1;
        step(1);
        status_clr = 1'b0;
        check("t5_lcd_ovf_clr", lcd_ovf, 0);
        step(12);
        check("t5_drained", lcd_q.size(), 0);
        check("t5_not_full", proc_lcd_full, 0);

        // 6: reset while waiting with two words queued
        proc_lcd_write = 1'b1;
        proc_lcd_data = 32'h60;
        step(1);
        p = cyc;
        lcd_q.push_back('{32'h60, p + 1});
        for (int i = 1; i < 4; i++) begin
            proc_lcd_data = 32'h60 + 32'(i);
            step(1);
        end
        proc_lcd_write = 1'b0;
        step(1);
        check("t6_second_write", lcd_write, 1);
        check("t6_second_data", lcd_data, 32'h61);
        #1;
        reset = 1'b1;
        #1;
        check("t6_write_async", lcd_write, 0);
        check("t6_data_async", lcd_data, 0);
        check("t6_full_async", proc_lcd_full, 0);
        step(1);
        reset = 1'b0;
        s0 = lcd_seen;
        step(10);
        check("t6_no_writes", lcd_seen, s0);
        check("t6_key_empty", proc_key_valid, 0);

        check("end_lcd_queue", lcd_q.size(), 0);
        check("end_key_queue", key_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
